// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-stage immediate generator with an elastic output FIFO.
// Extracts and extends the I/U/S/B/J/Z/SH immediate formats to XLEN bits and
// queues each result with its extop and sideband tag. Both sides use valid/ready.
// The handshake flags are registered, so out_ready has no combinational path to in_ready.
// Optional feature macro: IMM_ILLEGAL_EN adds a per-entry out_illegal flag.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [2:0]        in_extop,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [2:0]        out_extop,
`ifdef IMM_ILLEGAL_EN
    output logic              out_illegal,
`endif
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [31:0]      raw_c;
    logic [XLEN-1:0]  imm_c;
    logic             push_c;
    logic             pop_c;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr_nxt_c;
    logic [PTR_W-1:0] rd_ptr_nxt_c;
    logic [CNT_W-1:0] count_nxt_c;

    logic [XLEN-1:0]  mem_imm   [DEPTH];
    logic [2:0]       mem_extop [DEPTH];
    logic [TAG_W-1:0] mem_tag   [DEPTH];

    // The opcode field never contributes to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^in_inst[6:0];

    // Build a 32-bit immediate already extended to bit 31, then extend to XLEN.
    // The zero-extended formats keep bit 31 clear, so one signed widening covers all formats.
    always_comb begin
        raw_c = '0;
        case (in_extop)
            3'b000: raw_c = {{20{in_inst[31]}}, in_inst[31:20]};
            3'b001: raw_c = {in_inst[31:12], 12'b0};
            3'b010: raw_c = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'b011: raw_c = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
            3'b100: raw_c = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
            3'b101: raw_c = {27'b0, in_inst[19:15]};
            3'b110: begin
                if (XLEN == 64) begin
                    raw_c = {26'b0, in_inst[25:20]};
                end else begin
                    raw_c = {27'b0, in_inst[24:20]};
                end
            end
            default: raw_c = '0;
        endcase
        imm_c = XLEN'($signed(raw_c));
    end

`ifdef IMM_ILLEGAL_EN
    logic illegal_c;
    logic mem_ill [DEPTH];

    // Reserved extop, or a 6-bit shamt on a 32-bit datapath, flags the entry illegal.
    always_comb begin
        illegal_c = 1'b0;
        if (in_extop == 3'b111) begin
            illegal_c = 1'b1;
        end else if ((in_extop == 3'b110) && (XLEN == 32)) begin
            illegal_c = in_inst[25];
        end
    end

    // Per-entry illegal flag storage, cleared by reset only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ill[i] <= 1'b0;
            end
        end else if (push_c) begin
            mem_ill[wr_ptr] <= illegal_c;
        end
    end

    assign out_illegal = mem_ill[rd_ptr];
`endif

    // Flush suppresses both the push and the pop of its cycle.
    assign push_c = in_valid & in_ready & ~flush;
    assign pop_c  = out_valid & out_ready & ~flush;

    // Next pointer and occupancy; pointers wrap explicitly at DEPTH-1.
    always_comb begin
        wr_ptr_nxt_c = wr_ptr;
        rd_ptr_nxt_c = rd_ptr;
        count_nxt_c  = count;
        if (flush) begin
            wr_ptr_nxt_c = '0;
            rd_ptr_nxt_c = '0;
            count_nxt_c  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_nxt_c = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_c) begin
                rd_ptr_nxt_c = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_c, pop_c})
                2'b10:   count_nxt_c = count + 1'b1;
                2'b01:   count_nxt_c = count - 1'b1;
                default: count_nxt_c = count;
            endcase
        end
    end

    // Pointer, occupancy and handshake flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt_c;
            rd_ptr    <= rd_ptr_nxt_c;
            count     <= count_nxt_c;
            in_ready  <= (count_nxt_c != CNT_FULL);
            out_valid <= (count_nxt_c != '0);
        end
    end

    // Entry storage for imm, extop and tag, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i]   <= '0;
                mem_extop[i] <= '0;
                mem_tag[i]   <= '0;
            end
        end else if (push_c) begin
            mem_imm[wr_ptr]   <= imm_c;
            mem_extop[wr_ptr] <= in_extop;
            mem_tag[wr_ptr]   <= in_tag;
        end
    end

    assign out_imm   = mem_imm[rd_ptr];
    assign out_extop = mem_extop[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];

endmodule
